// File: rtl/fp_unpack_class_pkg.sv
// Shared definitions for the FP operand unpack/classify front end.
//   FMT_S / FMT_D   : operand format select (single NaN-boxed, double)
//   CLS_*           : bit positions inside the one-hot class vector
//   QNAN_S          : canonical single-precision quiet NaN
//   fp_classify()   : field flags -> one-hot class vector
package fp_unpack_class_pkg;

  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  localparam int CLS_W = 10;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  localparam logic [31:0] QNAN_S = 32'h7FC0_0000;

  // Exactly one bit is set for any combination of flags. NaNs ignore the sign.
  function automatic logic [CLS_W-1:0] fp_classify(
    input logic sgn,
    input logic exp_all1,
    input logic exp_zero,
    input logic man_zero,
    input logic man_msb
  );
    logic [CLS_W-1:0] cls;
    cls = '0;
    if (exp_all1) begin
      if (man_zero)     cls[sgn ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
      else if (man_msb) cls[CLS_QNAN] = 1'b1;
      else              cls[CLS_SNAN] = 1'b1;
    end else if (exp_zero) begin
      if (man_zero)     cls[sgn ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
      else              cls[sgn ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
    end else begin
      cls[sgn ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_unpack_class_unit.sv
// Combinational unpack + classify of one raw FP register operand.
//   op_i    [63:0] raw register value
//   fmt_i          0 = single (NaN-boxed in [31:0]), 1 = double
//   data_o  [64:0] {sign, magnitude}; magnitude compares unsigned across formats
//   class_o [9:0]  one-hot class
module fp_unpack_class_unit
  import fp_unpack_class_pkg::*;
(
  input  logic [63:0]      op_i,
  input  logic             fmt_i,
  output logic [64:0]      data_o,
  output logic [CLS_W-1:0] class_o
);

  logic        boxed;
  logic [31:0] s_op;

  // An improperly boxed single is treated as the canonical quiet NaN.
  assign boxed = (op_i[63:32] == 32'hFFFF_FFFF);
  assign s_op  = boxed ? op_i[31:0] : QNAN_S;

  always_comb begin
    data_o  = '0;
    class_o = '0;
    if (fmt_i == FMT_D) begin
      data_o  = {op_i[63], 1'b0, op_i[62:0]};
      class_o = fp_classify(op_i[63], &op_i[62:52], ~|op_i[62:52],
                            ~|op_i[51:0], op_i[51]);
    end else begin
      data_o  = {s_op[31], 33'b0, s_op[30:0]};
      class_o = fp_classify(s_op[31], &s_op[30:23], ~|s_op[30:23],
                            ~|s_op[22:0], s_op[22]);
    end
  end

endmodule

// File: rtl/fp_unpack_class.sv
// Operand front end for the FP compare/classify path: two-stage elastic
// valid/ready pipeline. S1 registers the raw operands; S2 registers the
// unpacked data and one-hot classes, and drives the outputs directly.
//   iClk/iRst               clock, async active-high reset
//   iValid/oReady           upstream handshake
//   iOperand1/2, iFmt, iRm, iTag   upstream payload
//   oValid/iReady           downstream handshake
//   oData1/2, oClass1/2, oRm, oTag downstream payload (S2 registers)
module fp_unpack_class
  import fp_unpack_class_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [63:0]      iOperand1,
  input  logic [63:0]      iOperand2,
  input  logic             iFmt,
  input  logic [2:0]       iRm,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [64:0]      oData1,
  output logic [64:0]      oData2,
  output logic [CLS_W-1:0] oClass1,
  output logic [CLS_W-1:0] oClass2,
  output logic [2:0]       oRm,
  output logic [TAG_W-1:0] oTag
);

  // Stage 1: raw operands
  logic             v1_q, v1_d;
  logic [63:0]      op1_q, op1_d;
  logic [63:0]      op2_q, op2_d;
  logic             fmt_q, fmt_d;
  logic [2:0]       rm1_q, rm1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // Stage 2: unpacked/classified
  logic             v2_q, v2_d;
  logic [64:0]      data1_q, data1_d;
  logic [64:0]      data2_q, data2_d;
  logic [CLS_W-1:0] cls1_q, cls1_d;
  logic [CLS_W-1:0] cls2_q, cls2_d;
  logic [2:0]       rm2_q, rm2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             ready_s1, ready_s2;
  logic [64:0]      unit_data1, unit_data2;
  logic [CLS_W-1:0] unit_cls1, unit_cls2;

  fp_unpack_class_unit u_unit1 (
    .op_i    (op1_q),
    .fmt_i   (fmt_q),
    .data_o  (unit_data1),
    .class_o (unit_cls1)
  );

  fp_unpack_class_unit u_unit2 (
    .op_i    (op2_q),
    .fmt_i   (fmt_q),
    .data_o  (unit_data2),
    .class_o (unit_cls2)
  );

  // Ready ripples back combinationally so a full pipe still accepts a new
  // beat in the same cycle the downstream takes the oldest one.
  assign ready_s2 = ~v2_q | iReady;
  assign ready_s1 = ~v1_q | ready_s2;
  assign oReady   = ready_s1;

  always_comb begin
    v1_d    = v1_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    fmt_d   = fmt_q;
    rm1_d   = rm1_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    cls1_d  = cls1_q;
    cls2_d  = cls2_q;
    rm2_d   = rm2_q;
    tag2_d  = tag2_q;

    if (ready_s1) begin
      v1_d = iValid;
      if (iValid) begin
        op1_d  = iOperand1;
        op2_d  = iOperand2;
        fmt_d  = iFmt;
        rm1_d  = iRm;
        tag1_d = iTag;
      end
    end

    if (ready_s2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data1_d = unit_data1;
        data2_d = unit_data2;
        cls1_d  = unit_cls1;
        cls2_d  = unit_cls2;
        rm2_d   = rm1_q;
        tag2_d  = tag1_q;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      v1_q    <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      fmt_q   <= 1'b0;
      rm1_q   <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
      cls1_q  <= '0;
      cls2_q  <= '0;
      rm2_q   <= '0;
      tag2_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      fmt_q   <= fmt_d;
      rm1_q   <= rm1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      cls1_q  <= cls1_d;
      cls2_q  <= cls2_d;
      rm2_q   <= rm2_d;
      tag2_q  <= tag2_d;
    end
  end

  assign oValid  = v2_q;
  assign oData1  = data1_q;
  assign oData2  = data2_q;
  assign oClass1 = cls1_q;
  assign oClass2 = cls2_q;
  assign oRm     = rm2_q;
  assign oTag    = tag2_q;

endmodule

// File: tb/tb_fp_unpack_class.sv
// Scoreboard bench for fp_unpack_class: expected results are computed by a
// reference model at input transfer and compared at output transfer.
module tb_fp_unpack_class;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] op1, op2;
  logic        fmt;
  logic [2:0]  rm;
  logic [4:0]  tag;
  logic        out_valid, out_ready;
  logic [64:0] data1, data2;
  logic [9:0]  cls1, cls2;
  logic [2:0]  rm_o;
  logic [4:0]  tag_o;

  always #5 clk = ~clk;

  fp_unpack_class #(.TAG_W(5)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iValid    (in_valid),
    .oReady    (in_ready),
    .iOperand1 (op1),
    .iOperand2 (op2),
    .iFmt      (fmt),
    .iRm       (rm),
    .iTag      (tag),
    .oValid    (out_valid),
    .iReady    (out_ready),
    .oData1    (data1),
    .oData2    (data2),
    .oClass1   (cls1),
    .oClass2   (cls2),
    .oRm       (rm_o),
    .oTag      (tag_o)
  );

  typedef struct {
    logic [64:0] d1, d2;
    logic [9:0]  c1, c2;
    logic [2:0]  rm;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   lat_en   = 1'b0;
  logic acc, last_ovalid, last_ordy;
  logic [64:0] obs_d1, obs_d2;
  logic [9:0]  obs_c1, obs_c2;
  logic [2:0]  obs_rm;
  logic [4:0]  obs_tag;

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [74:0] ref_unpack(input logic [63:0] op, input logic f);
    logic [31:0] w;
    logic        sgn, e_max, e_min, m_nil, m_top;
    logic [64:0] d;
    logic [9:0]  c;
    if (f) begin
      sgn   = op[63];
      e_max = (op[62:52] == 11'h7FF);
      e_min = (op[62:52] == 11'h000);
      m_nil = (op[51:0] == 52'h0);
      m_top = op[51];
      d     = {op[63], 1'b0, op[62:0]};
    end else begin
      w     = (op[63:32] == 32'hFFFF_FFFF) ? op[31:0] : 32'h7FC0_0000;
      sgn   = w[31];
      e_max = (w[30:23] == 8'hFF);
      e_min = (w[30:23] == 8'h00);
      m_nil = (w[22:0] == 23'h0);
      m_top = w[22];
      d     = {w[31], 33'h0, w[30:0]};
    end
    if (e_max && !m_nil)     c = m_top ? 10'h200 : 10'h100;
    else if (e_max)          c = sgn ? 10'h001 : 10'h080;
    else if (e_min && m_nil) c = sgn ? 10'h008 : 10'h010;
    else if (e_min)          c = sgn ? 10'h004 : 10'h020;
    else                     c = sgn ? 10'h002 : 10'h040;
    return {d, c};
  endfunction

  // One clock: sample/compare at negedge, then step to just after posedge.
  task automatic tick();
    exp_t        e;
    logic        exp_rdy;
    logic [74:0] r1, r2;
    @(negedge clk);
    exp_rdy     = (sb.size() < 2) || out_ready;
    last_ovalid = out_valid;
    last_ordy   = in_ready;
    check_val("oReady", 128'(in_ready), 128'(exp_rdy));
    if (out_valid && sb.size() == 0) begin
      check_val("spurious_out", 128'(out_valid), 128'(0));
    end else if (out_valid && !out_ready) begin
      check_val("hold_data1", 128'(data1), 128'(sb[0].d1));
      check_val("hold_tag", 128'(tag_o), 128'(sb[0].tag));
    end else if (out_valid && out_ready) begin
      e = sb.pop_front();
      check_val("data1", 128'(data1), 128'(e.d1));
      check_val("data2", 128'(data2), 128'(e.d2));
      check_val("class1", 128'(cls1), 128'(e.c1));
      check_val("class2", 128'(cls2), 128'(e.c2));
      check_val("rm", 128'(rm_o), 128'(e.rm));
      check_val("tag", 128'(tag_o), 128'(e.tag));
      if (lat_en) check_val("latency", 128'(cyc - e.cyc), 128'(2));
      obs_d1 = data1; obs_d2 = data2; obs_c1 = cls1; obs_c2 = cls2;
      obs_rm = rm_o;  obs_tag = tag_o;
    end
    acc = in_valid && in_ready;
    if (acc) begin
      r1    = ref_unpack(op1, fmt);
      r2    = ref_unpack(op2, fmt);
      e.d1  = r1[74:10];
      e.c1  = r1[9:0];
      e.d2  = r2[74:10];
      e.c2  = r2[9:0];
      e.rm  = rm;
      e.tag = tag;
      e.cyc = cyc;
      sb.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic f,
                       input logic [2:0] r, input logic [4:0] t);
    op1 = a; op2 = b; fmt = f; rm = r; tag = t; in_valid = 1'b1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic f,
                      input logic [2:0] r, input logic [4:0] t);
    int k;
    drive(a, b, f, r, t);
    k = 0;
    acc = 1'b0;
    while (!acc && k < 50) begin
      tick();
      k++;
    end
    if (!acc) check_val("send_timeout", 128'(acc), 128'(1));
  endtask

  task automatic one_shot(input logic [63:0] a, input logic [63:0] b, input logic f,
                          input logic [2:0] r, input logic [4:0] t);
    send(a, b, f, r, t);
    in_valid = 1'b0;
    tick();
    check_val("lat_gap", 128'(last_ovalid), 128'(0));
    tick();
    check_val("lat_out", 128'(last_ovalid), 128'(1));
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      tick();
      k++;
    end
    check_val("drain", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: ;
      1: v[63:32] = 32'hFFFF_FFFF;
      2: begin v[63:32] = 32'hFFFF_FFFF; v[30:23] = 8'hFF; end
      3: v = {v[63], 63'h0};
      4: v[62:52] = 11'h7FF;
      5: v[62:52] = 11'h000;
      6: v[63:32] = 32'h1234_5678;
      default: begin v[63:32] = 32'hFFFF_FFFF; v[30:23] = 8'h00; end
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; fmt = 1'b0; rm = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ovalid", 128'(out_valid), 128'(0));
    check_val("rst_data1", 128'(data1), 128'(0));
    check_val("rst_class2", 128'(cls2), 128'(0));
    check_val("rst_tag", 128'(tag_o), 128'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_oready", 128'(in_ready), 128'(1));

    // Directed vectors, exact 2-cycle latency on an empty pipe
    lat_en = 1'b1;
    one_shot(64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b1, 3'd1, 5'd1);
    check_val("t1_data1", 128'(obs_d1), 128'(65'h0_3FF0_0000_0000_0000));
    check_val("t1_class1", 128'(obs_c1), 128'(10'h040));
    check_val("t1_sign2", 128'(obs_d2[64]), 128'(1));
    check_val("t1_class2", 128'(obs_c2), 128'(10'h002));
    check_val("t1_rm", 128'(obs_rm), 128'(3'd1));

    one_shot(64'hFFFF_FFFF_7F80_0001, 64'h0000_0000_3F80_0000, 1'b0, 3'd2, 5'd2);
    check_val("t2_class1", 128'(obs_c1), 128'(10'h100));
    check_val("t2_data2", 128'(obs_d2), 128'(65'h0_0000_0000_7FC0_0000));
    check_val("t2_class2", 128'(obs_c2), 128'(10'h200));

    one_shot(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 3'd0, 5'd3);
    check_val("t3_negzero", 128'(obs_c1), 128'(10'h008));
    check_val("t3_possub", 128'(obs_c2), 128'(10'h020));
    one_shot(64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b1, 3'd4, 5'd4);
    check_val("t3_neginf", 128'(obs_c1), 128'(10'h001));
    check_val("t3_qnan_d", 128'(obs_c2), 128'(10'h200));

    // Back-pressure: downstream stalled for 3 cycles under 4 back-to-back beats
    lat_en = 1'b0;
    out_ready = 1'b0;
    drive(64'h4000_0000_0000_0000, 64'h0, 1'b1, 3'd3, 5'd10); tick();
    drive(64'hC008_0000_0000_0000, 64'h1, 1'b1, 3'd3, 5'd11); tick();
    drive(64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 3'd3, 5'd12); tick();
    check_val("bp_oready_low", 128'(last_ordy), 128'(0));
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 3'd3, 5'd12);
    send(64'hFFFF_FFFF_FF80_0000, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0, 3'd3, 5'd13);
    drain();

    // Full throughput: 16 beats, output valid continuous once the pipe fills
    lat_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(rand_op(), rand_op(), i[0], 3'(i), 5'(i));
      else in_valid = 1'b0;
      tick();
      if (i >= 2) check_val("tp_ovalid", 128'(last_ovalid), 128'(1));
    end
    drain();

    // Async reset with both stages full
    out_ready = 1'b0;
    send(64'h3FF0_0000_0000_0001, 64'h1, 1'b1, 3'd5, 5'd20);
    send(64'h3FF0_0000_0000_0002, 64'h2, 1'b1, 3'd5, 5'd21);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("ar_ovalid", 128'(out_valid), 128'(0));
    check_val("ar_data1", 128'(data1), 128'(0));
    check_val("ar_data2", 128'(data2), 128'(0));
    check_val("ar_class1", 128'(cls1), 128'(0));
    check_val("ar_rm", 128'(rm_o), 128'(0));
    check_val("ar_tag", 128'(tag_o), 128'(0));
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    one_shot(64'h0010_0000_0000_0000, 64'h800F_FFFF_FFFF_FFFF, 1'b1, 3'd6, 5'd22);
    check_val("ar_post_class2", 128'(obs_c2), 128'(10'h004));

    // Random traffic with random back-pressure
    lat_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
